// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch: valid/ready pipeline stage latch with a 2-entry skid buffer.
// The main register drives data_o. The skid register catches one payload
// accepted while downstream stalls. valid_o, ready_o and count_o are flops,
// so ready_i has no combinational path to ready_o. flush empties the latch.
// Optional stall/flush performance counters are built only when the macro
// PIPE_PERF_CNT_EN is defined. Otherwise both counter ports read zero.
module pipe_skid_latch #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic [1:0]          count_q, count_d;
    logic                in_fire;
    logic                out_fire;

    assign in_fire  = valid_i & ready_q;
    assign out_fire = valid_q & ready_i;

    // Next-state, payload movement and registered-output decode
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = data_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = data_i;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = data_i;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = RESET_VAL;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so only the drain side can fire
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = RESET_VAL;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_FULL);
        case (state_d)
            ST_EMPTY: count_d = 2'd0;
            ST_ONE:   count_d = 2'd1;
            ST_FULL:  count_d = 2'd2;
            default:  count_d = 2'd0;
        endcase
    end

    // State, payload registers and registered handshake/occupancy outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign data_o  = main_q;
    assign count_o = count_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating increment of the stall and flush event counters
    always_comb begin
        if (valid_q && !ready_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed self-checking bench for pipe_skid_latch (DATA_W=32, CNT_W=4).
// Inputs change 1 time unit after the rising edge. Outputs are sampled at the same point.
module tb_pipe_skid_latch;

    logic        CLK;
    logic        nRST;
    logic        flush;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [1:0]  count_o;
    logic [3:0]  stall_cnt_o;
    logic [3:0]  flush_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    pipe_skid_latch #(
        .DATA_W    (32),
        .RESET_VAL (32'h0000_0000),
        .CNT_W     (4)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .flush       (flush),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .count_o     (count_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected counter value: the counters exist only with the perf macro
    function automatic logic [31:0] cnt_exp(input int v);
`ifdef PIPE_PERF_CNT_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic r,
                             input logic [1:0] c, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".ready"}, 32'(ready_o), 32'(r));
        chk({tag, ".count"}, 32'(count_o), 32'(c));
        chk({tag, ".data"},  data_o, d);
    endtask

    logic [31:0] stream_v [3];

    initial begin
        nRST = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = 32'h0;
        stream_v[0] = 32'h1; stream_v[1] = 32'h2; stream_v[2] = 32'h3;
        #12;
        chk_state("reset", 1'b0, 1'b1, 2'd0, 32'h0);
        chk("reset.stall_cnt", 32'(stall_cnt_o), 32'h0);
        chk("reset.flush_cnt", 32'(flush_cnt_o), 32'h0);
        nRST = 1'b1;

        // 1: single payload, one cycle latency, then drained
        valid_i = 1'b1; data_i = 32'hA5A5_0001; ready_i = 1'b1;
        step();
        chk_state("t1.accept", 1'b1, 1'b1, 2'd1, 32'hA5A5_0001);
        valid_i = 1'b0;
        step();
        chk_state("t1.drain", 1'b0, 1'b1, 2'd0, 32'h0);

        // 2: full-throughput stream
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; data_i = stream_v[i]; ready_i = 1'b1;
            step();
            chk_state($sformatf("t2.beat%0d", i), 1'b1, 1'b1, 2'd1, stream_v[i]);
        end
        valid_i = 1'b0;
        step();
        chk_state("t2.end", 1'b0, 1'b1, 2'd0, 32'h0);

        // 3: fill to FULL under stall, blocked input, then drain in order
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h10;
        step();
        chk_state("t3.one", 1'b1, 1'b1, 2'd1, 32'h10);
        data_i = 32'h11;
        step();
        chk_state("t3.full", 1'b1, 1'b0, 2'd2, 32'h10);
        data_i = 32'h99;
        step();
        chk_state("t3.hold", 1'b1, 1'b0, 2'd2, 32'h10);
        valid_i = 1'b0; ready_i = 1'b1;
        step();
        chk_state("t3.out11", 1'b1, 1'b1, 2'd1, 32'h11);
        step();
        chk_state("t3.empty", 1'b0, 1'b1, 2'd0, 32'h0);
        chk("t3.stall_cnt", 32'(stall_cnt_o), cnt_exp(2));

        // 4: flush from FULL drops the same-cycle input
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h20;
        step();
        data_i = 32'h21;
        step();
        chk_state("t4.full", 1'b1, 1'b0, 2'd2, 32'h20);
        flush = 1'b1; data_i = 32'h22;
        step();
        chk_state("t4.flush", 1'b0, 1'b1, 2'd0, 32'h0);
        chk("t4.stall_cnt", 32'(stall_cnt_o), cnt_exp(4));
        chk("t4.flush_cnt", 32'(flush_cnt_o), cnt_exp(1));
        flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        step();
        chk_state("t4.no22", 1'b0, 1'b1, 2'd0, 32'h0);

        // flush held for two cycles while EMPTY with valid input
        flush = 1'b1; valid_i = 1'b1; data_i = 32'h33;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_state($sformatf("flushhold%0d", i), 1'b0, 1'b1, 2'd0, 32'h0);
        end
        flush = 1'b0; valid_i = 1'b0;
        step();
        chk_state("flushhold.after", 1'b0, 1'b1, 2'd0, 32'h0);
        chk("flushhold.flush_cnt", 32'(flush_cnt_o), cnt_exp(3));

        // long stall: data_o stable, stall counter saturates
        valid_i = 1'b1; data_i = 32'h44; ready_i = 1'b0;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("stall%0d.data", i), data_o, 32'h44);
        end
        chk("stall.stall_cnt", 32'(stall_cnt_o), cnt_exp(15));
        chk("stall.flush_cnt", 32'(flush_cnt_o), cnt_exp(3));

        // 5: asynchronous reset while FULL
        valid_i = 1'b1; data_i = 32'h45;
        step();
        chk_state("t5.full", 1'b1, 1'b0, 2'd2, 32'h44);
        valid_i = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk_state("t5.async", 1'b0, 1'b1, 2'd0, 32'h0);
        chk("t5.stall_cnt", 32'(stall_cnt_o), 32'h0);
        chk("t5.flush_cnt", 32'(flush_cnt_o), 32'h0);
        #2 nRST = 1'b1;
        ready_i = 1'b1;
        step();
        chk_state("t5.after", 1'b0, 1'b1, 2'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
